// File: rtl/sram_resp_confreg.sv
// Word RAM shared by instruction fetch and data load/store, plus a small config-register window.
// Both ports have a fixed 1-cycle read latency. RAM reads are read-first, and RAM contents are not reset.
module sram_resp_confreg #(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] CONF_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [13:0] OFF_LED     = 14'd0;
  localparam logic [13:0] OFF_SWITCH  = 14'd1;
  localparam logic [13:0] OFF_TIMER   = 14'd2;
  localparam logic [13:0] OFF_SCRATCH = 14'd3;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] inst_idx;
  logic [ADDR_W-1:0] data_idx;
  logic [13:0]       conf_word;
  logic              conf_sel;
  logic              data_wr;
  logic              ram_wr;
  logic              conf_wr;
  logic [31:0]       conf_rdata;
  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;
  logic [31:0]       timer;
  logic [31:0]       scratch;
  logic              unused_bits;

  assign inst_idx    = inst_sram_addr[ADDR_W+1:2];
  assign data_idx    = data_sram_addr[ADDR_W+1:2];
  assign conf_word   = data_sram_addr[15:2];
  assign conf_sel    = (data_sram_addr[31:16] == CONF_HI);
  assign data_wr     = data_sram_en && (data_sram_wen != 4'b0000);
  assign ram_wr      = data_wr && !conf_sel && !rst;
  assign conf_wr     = data_wr && conf_sel;
  assign unused_bits = ^{inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0], data_sram_addr[1:0]};

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] wen);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    conf_rdata = 32'h0;
    case (conf_word)
      OFF_LED:     conf_rdata = {16'h0, led};
      OFF_SWITCH:  conf_rdata = {24'h0, sw_sync};
      OFF_TIMER:   conf_rdata = timer;
      OFF_SCRATCH: conf_rdata = scratch;
      default:     conf_rdata = 32'h0;
    endcase
  end

  // RAM array has no reset so it maps onto block RAM; read-first falls out of NBA ordering.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_sram_rdata <= 32'h0;
      data_sram_rdata <= 32'h0;
      led             <= 16'h0;
      timer           <= 32'h0;
      scratch         <= 32'h0;
      sw_meta         <= 8'h0;
      sw_sync         <= 8'h0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
      if (inst_sram_en) inst_sram_rdata <= mem[inst_idx];
      if (data_sram_en) data_sram_rdata <= conf_sel ? conf_rdata : mem[data_idx];
      if (conf_wr && conf_word == OFF_LED) begin
        if (data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
      end
      // A timer write replaces this cycle's increment so the written value reads back exactly.
      if (conf_wr && conf_word == OFF_TIMER) timer <= lane_merge(timer, data_sram_wdata, data_sram_wen);
      else                                   timer <= timer + 32'd1;
      if (conf_wr && conf_word == OFF_SCRATCH)
        scratch <= lane_merge(scratch, data_sram_wdata, data_sram_wen);
    end
  end

endmodule

// File: tb/tb_sram_resp_confreg.sv
// Self-checking bench for sram_resp_confreg: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sram_resp_confreg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_sram_en = 1'b0;
  logic [31:0] inst_sram_addr = 32'h0;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch = 8'h0;
  logic [15:0] led;

  int n_cmp  = 0;
  int n_fail = 0;

  sram_resp_confreg dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .switch(switch), .led(led)
  );

  always #5 clk = ~clk;

  // Behavioural model: sparse word store plus register values, updated once per accepted edge.
  bit [31:0] m_mem [int];
  bit [31:0] m_led, m_timer, m_scratch, m_sw1, m_sw2;
  bit [31:0] exp_i, exp_d;
  bit        ki, kd;

  function automatic bit [31:0] apply_lanes(bit [31:0] old_w, bit [31:0] new_w, bit [3:0] wen);
    bit [31:0] r = old_w;
    for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_i = 0; exp_d = 0; ki = 1; kd = 1;
      m_led = 0; m_timer = 0; m_scratch = 0; m_sw1 = 0; m_sw2 = 0;
    end else begin
      int  ikey, dkey, off;
      bit  conf, timer_written;
      ikey = int'((inst_sram_addr / 4) % 16384);
      dkey = int'((data_sram_addr / 4) % 16384);
      conf = (data_sram_addr / 65536) == 32'hBFAF;
      off  = int'(data_sram_addr % 65536) / 4;
      timer_written = 0;
      if (inst_sram_en) begin
        ki = m_mem.exists(ikey);
        exp_i = ki ? m_mem[ikey] : 0;
      end
      if (data_sram_en) begin
        if (conf) begin
          kd = 1;
          exp_d = (off == 0) ? m_led : (off == 1) ? m_sw2 : (off == 2) ? m_timer :
                  (off == 3) ? m_scratch : 0;
        end else begin
          kd = m_mem.exists(dkey);
          exp_d = kd ? m_mem[dkey] : 0;
        end
      end
      if (data_sram_en && data_sram_wen != 0) begin
        if (!conf) begin
          // Partial write into an unknown word leaves it unknown; only full writes create entries.
          if (m_mem.exists(dkey)) m_mem[dkey] = apply_lanes(m_mem[dkey], data_sram_wdata, data_sram_wen);
          else if (data_sram_wen == 4'hF) m_mem[dkey] = data_sram_wdata;
        end else if (off == 0) begin
          m_led = apply_lanes(m_led, data_sram_wdata, data_sram_wen & 4'b0011);
        end else if (off == 2) begin
          m_timer = apply_lanes(m_timer, data_sram_wdata, data_sram_wen);
          timer_written = 1;
        end else if (off == 3) begin
          m_scratch = apply_lanes(m_scratch, data_sram_wdata, data_sram_wen);
        end
      end
      if (!timer_written) m_timer = m_timer + 1;
      m_sw2 = m_sw1;
      m_sw1 = {24'h0, switch};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_led", {16'h0, led}, m_led);
    if (ki) check("model_inst_rdata", inst_sram_rdata, exp_i);
    if (kd) check("model_data_rdata", data_sram_rdata, exp_d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    inst_sram_en = 0; data_sram_en = 0; data_sram_wen = 0;
  endtask

  task automatic dacc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    data_sram_en = 1; data_sram_addr = a; data_sram_wen = w; data_sram_wdata = d;
    tick();
  endtask

  initial begin
    tick(); tick();
    check("reset_data_rdata", data_sram_rdata, 32'h0);
    check("reset_inst_rdata", inst_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    rst = 0;
    tick();

    // RAM round trip
    dacc(32'h0000_0040, 4'hF, 32'h1234_5678);
    dacc(32'h0000_0040, 4'h0, 32'h0);
    check("ram_round_trip", data_sram_rdata, 32'h1234_5678);
    tick();
    check("rdata_hold", data_sram_rdata, 32'h1234_5678);

    // Byte lanes with read-first
    dacc(32'h0000_0080, 4'hF, 32'hFFFF_FFFF);
    dacc(32'h0000_0080, 4'b0010, 32'h0000_AB00);
    check("write_cycle_old_word", data_sram_rdata, 32'hFFFF_FFFF);
    dacc(32'h0000_0080, 4'h0, 32'h0);
    check("byte_lane_merge", data_sram_rdata, 32'hFFFF_ABFF);
    dacc(32'h0001_0080, 4'h0, 32'h0);
    check("ram_alias", data_sram_rdata, 32'hFFFF_ABFF);

    // Same-cycle fetch and store to one index
    inst_sram_en = 1; inst_sram_addr = 32'h0000_0080;
    dacc(32'h0000_0080, 4'hF, 32'hCAFE_F00D);
    check("inst_conflict_old", inst_sram_rdata, 32'hFFFF_ABFF);
    inst_sram_en = 1; inst_sram_addr = 32'hBFAF_0080;
    tick();
    check("inst_after_write", inst_sram_rdata, 32'hCAFE_F00D);

    // Timer load and wrap
    dacc(32'hBFAF_0008, 4'hF, 32'hFFFF_FFFE);
    dacc(32'hBFAF_0008, 4'h0, 32'h0);
    check("timer_rd0", data_sram_rdata, 32'hFFFF_FFFE);
    dacc(32'hBFAF_0008, 4'h0, 32'h0);
    check("timer_rd1", data_sram_rdata, 32'hFFFF_FFFF);
    dacc(32'hBFAF_0008, 4'h0, 32'h0);
    check("timer_wrap", data_sram_rdata, 32'h0000_0000);

    // Switch synchronizer, LED, scratch, unmapped offsets
    switch = 8'hA5;
    tick();
    dacc(32'hBFAF_0004, 4'h0, 32'h0);
    check("switch_early", data_sram_rdata, 32'h0);
    dacc(32'hBFAF_0004, 4'h0, 32'h0);
    check("switch_sync", data_sram_rdata, 32'h0000_00A5);
    dacc(32'hBFAF_0004, 4'hF, 32'h1111_1111);
    dacc(32'h0000_0004, 4'hF, 32'h2222_2222);
    dacc(32'hBFAF_0000, 4'hF, 32'h0000_F00F);
    check("led_write", {16'h0, led}, 32'h0000_F00F);
    dacc(32'h0000_0004, 4'h0, 32'h0);
    check("ram_idx1_untouched", data_sram_rdata, 32'h2222_2222);
    dacc(32'hBFAF_0000, 4'b0010, 32'h0000_3300);
    check("led_readback_old", data_sram_rdata, 32'h0000_F00F);
    check("led_partial", {16'h0, led}, 32'h0000_330F);
    dacc(32'hBFAF_000C, 4'hF, 32'h0);
    dacc(32'hBFAF_000C, 4'b0101, 32'hAABB_CCDD);
    dacc(32'hBFAF_000C, 4'h0, 32'h0);
    check("scratch_lanes", data_sram_rdata, 32'h00BB_00DD);
    dacc(32'hBFAF_0010, 4'h0, 32'h0);
    check("unmapped_zero", data_sram_rdata, 32'h0);
    dacc(32'hBFAF_0004, 4'h0, 32'h0);
    check("switch_write_ignored", data_sram_rdata, 32'h0000_00A5);

    // en=0 with wen set must not write
    data_sram_en = 0; data_sram_wen = 4'hF; data_sram_addr = 32'h40; data_sram_wdata = 32'hDEAD_BEEF;
    tick();
    dacc(32'h0000_0040, 4'h0, 32'h0);
    check("no_write_without_en", data_sram_rdata, 32'h1234_5678);

    // Reset right after a read, with a store presented during reset
    dacc(32'h0000_0080, 4'h0, 32'h0);
    rst = 1;
    #2;
    check("midreset_rdata", data_sram_rdata, 32'h0);
    check("midreset_led", {16'h0, led}, 32'h0);
    data_sram_en = 1; data_sram_addr = 32'h40; data_sram_wen = 4'hF; data_sram_wdata = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    data_sram_en = 0; data_sram_wen = 0;
    rst = 0;
    dacc(32'hBFAF_0008, 4'h0, 32'h0);
    check("timer_after_reset", data_sram_rdata, 32'h0);
    dacc(32'h0000_0040, 4'h0, 32'h0);
    check("ram_survives_reset", data_sram_rdata, 32'h1234_5678);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
